shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Sequential shifter: moves the latched operand one bit per clock and pulses done when finished.
// Defining SHIFT_SEQ_ARITH_EN adds the arith input for sign-filling right shifts.
module shift_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dir,
  input  logic [2:0] amount,
  input  logic [7:0] data_in,
`ifdef SHIFT_SEQ_ARITH_EN
  input  logic       arith,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       carry_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [7:0] work_reg, work_next;
  logic [2:0] count, count_next;
  logic       carry, carry_next;
  logic       dir_q, dir_next;
  logic       fill;
`ifdef SHIFT_SEQ_ARITH_EN
  logic       arith_q, arith_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      work_reg <= 8'h00;
      count    <= 3'd0;
      carry    <= 1'b0;
      dir_q    <= 1'b0;
`ifdef SHIFT_SEQ_ARITH_EN
      arith_q  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      work_reg <= work_next;
      count    <= count_next;
      carry    <= carry_next;
      dir_q    <= dir_next;
`ifdef SHIFT_SEQ_ARITH_EN
      arith_q  <= arith_next;
`endif
    end
  end

  // Sign fill replicates the current MSB, so it tracks the register as it shifts.
`ifdef SHIFT_SEQ_ARITH_EN
  assign fill = arith_q & work_reg[7];
`else
  assign fill = 1'b0;
`endif

  always_comb begin
    state_next = state;
    work_next  = work_reg;
    count_next = count;
    carry_next = carry;
    dir_next   = dir_q;
`ifdef SHIFT_SEQ_ARITH_EN
    arith_next = arith_q;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          work_next  = data_in;
          count_next = amount;
          carry_next = 1'b0;
          dir_next   = dir;
`ifdef SHIFT_SEQ_ARITH_EN
          arith_next = arith;
`endif
          state_next = (amount == 3'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (dir_q) begin
          carry_next = work_reg[7];
          work_next  = {work_reg[6:0], 1'b0};
        end else begin
          carry_next = work_reg[0];
          work_next  = {fill, work_reg[7:1]};
        end
        count_next = count - 3'd1;
        if (count == 3'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign result    = work_reg;
  assign carry_out = carry;

endmodule
